pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RV32I pipeline. Detects load-use hazards

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/load_use_detect.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes and the hazard sequencer state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_e;

  // Width of a down-counter that must hold the larger of two cycle counts.
  function automatic int unsigned hold_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection: decodes which source operands the ID
// instruction reads and compares them with the destination of a load in EX.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic use_rs1;
  logic use_rs2;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: use_rs1 = 1'b1;
      OP_STORE, OP_BRANCH, OP_REG: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, data-memory freezes, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES    = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_inst,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             pc_sel_branch,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned     HOLD_W       = hold_width(LOAD_USE_CYCLES, FLUSH_CYCLES);
  localparam logic [HOLD_W-1:0] STALL_RELOAD = HOLD_W'(LOAD_USE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] FLUSH_RELOAD = HOLD_W'(FLUSH_CYCLES - 1);

  hz_state_e         state, state_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic              pending_flush, pend_nxt;
  logic              load_use;
  logic              mem_wait;
  logic              hold_last;
  logic              pc_we_c, sel_c, ifwe_c, flush_c, bub_c, exwe_c;
  logic              unused_inst_bits;

  load_use_detect u_lud (
    .opcode      (id_inst[6:0]),
    .rs1         (id_inst[19:15]),
    .rs2         (id_inst[24:20]),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};
  assign mem_wait  = mem_req && !mem_ready;
  assign hold_last = (hold <= HOLD_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      hold          <= '0;
      pending_flush <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold          <= hold_nxt;
      pending_flush <= pend_nxt;
    end
  end

  // The first cycle of a stall or flush is decoded directly from the inputs in
  // RUN/MEM_WAIT; the LOAD_STALL and FLUSH states only cover the remaining cycles.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    pend_nxt  = pending_flush;
    pc_we_c   = 1'b0;
    sel_c     = 1'b0;
    ifwe_c    = 1'b0;
    flush_c   = 1'b0;
    bub_c     = 1'b0;
    exwe_c    = 1'b0;
    if (mem_wait) begin
      state_nxt = MEM_WAIT;
      hold_nxt  = '0;
      pend_nxt  = pending_flush | ex_branch_taken;
    end else if (ex_branch_taken || pending_flush) begin
      pc_we_c  = 1'b1;
      sel_c    = 1'b1;
      ifwe_c   = 1'b1;
      flush_c  = 1'b1;
      bub_c    = 1'b1;
      exwe_c   = 1'b1;
      pend_nxt = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        hold_nxt  = FLUSH_RELOAD;
      end else begin
        state_nxt = RUN;
        hold_nxt  = '0;
      end
    end else if (state == FLUSH) begin
      pc_we_c = 1'b1;
      ifwe_c  = 1'b1;
      flush_c = 1'b1;
      bub_c   = 1'b1;
      exwe_c  = 1'b1;
      if (hold_last) begin
        state_nxt = RUN;
        hold_nxt  = '0;
      end else begin
        hold_nxt = hold - 1'b1;
      end
    end else if (state == LOAD_STALL) begin
      bub_c  = 1'b1;
      exwe_c = 1'b1;
      if (hold_last) begin
        state_nxt = RUN;
        hold_nxt  = '0;
      end else begin
        hold_nxt = hold - 1'b1;
      end
    end else if (load_use) begin
      bub_c  = 1'b1;
      exwe_c = 1'b1;
      if (LOAD_USE_CYCLES > 1) begin
        state_nxt = LOAD_STALL;
        hold_nxt  = STALL_RELOAD;
      end else begin
        state_nxt = RUN;
        hold_nxt  = '0;
      end
    end else begin
      pc_we_c   = 1'b1;
      ifwe_c    = 1'b1;
      exwe_c    = 1'b1;
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Outputs are forced low for the whole time reset is asserted.
  assign pc_we         = pc_we_c & rst_n;
  assign pc_sel_branch = sel_c   & rst_n;
  assign if_id_we      = ifwe_c  & rst_n;
  assign if_id_flush   = flush_c & rst_n;
  assign id_ex_bubble  = bub_c   & rst_n;
  assign ex_mem_we     = exwe_c  & rst_n;
  assign state_o       = state;

endmodule
